// File: rtl/keypad_scan_encoder_if.sv
// Digit-entry interface between the keypad encoder (producer) and the
// number-assembly block (consumer). num is valid whenever load_num pulses.
interface keypad_scan_encoder_if;
  logic [3:0] num;
  logic       load_num;
  logic       key_held;

  modport master (output num, output load_num, output key_held);
  modport slave  (input  num, input  load_num, input  key_held);
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: rotates a one-cold column drive, debounces a
// detected press on its latched row, emits one key code per press and
// then waits for a debounced release before scanning again.
module keypad_scan_encoder #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    row_i,
  output logic [3:0]                    col_o,
  keypad_scan_encoder_if.master         key_if
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;

  state_t        state, state_n;
  logic [1:0]    col, col_n;
  logic [1:0]    row_lat, row_n;
  logic [SW-1:0] div_cnt, div_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [3:0]    num_r, num_n;
  logic [3:0]    row_m, row_s;
  logic [1:0]    low_row;

  // Key legend by row/column; letter keys and */# get their control codes.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hD;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hC;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hB;
      default:  code = 4'hF;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous, active-low row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_i;
      row_s <= row_m;
    end
  end

  // Lowest-index active row wins when several keys share the scanned column.
  always_comb begin
    low_row = 2'd3;
    if (!row_s[0])      low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
  end

  // State register and scan/debounce datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      col     <= 2'd0;
      row_lat <= 2'd0;
      div_cnt <= '0;
      deb_cnt <= '0;
      num_r   <= 4'h0;
    end else begin
      state   <= state_n;
      col     <= col_n;
      row_lat <= row_n;
      div_cnt <= div_n;
      deb_cnt <= deb_n;
      num_r   <= num_n;
    end
  end

  // Next-state logic; num is loaded on the way into EMIT so it is already valid during the strobe.
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row_lat;
    div_n   = div_cnt;
    deb_n   = deb_cnt;
    num_n   = num_r;
    case (state)
      SCAN: begin
        if (div_cnt == SCAN_LAST) begin
          div_n = '0;
          if (row_s != 4'hF) begin
            row_n   = low_row;
            deb_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_s[row_lat]) begin
          if (deb_cnt == DEB_LAST) begin
            num_n   = key_code(row_lat, col);
            deb_n   = '0;
            state_n = EMIT;
          end else if (deb_cnt != DEB_MAX) begin
            deb_n = deb_cnt + 1'b1;
          end
        end else begin
          deb_n   = '0;
          div_n   = '0;
          col_n   = col + 2'd1;
          state_n = SCAN;
        end
      end
      EMIT: begin
        deb_n   = '0;
        state_n = HOLD;
      end
      HOLD: begin
        if (row_s[row_lat]) begin
          if (deb_cnt == DEB_LAST) begin
            deb_n   = '0;
            div_n   = '0;
            col_n   = 2'd0;
            state_n = SCAN;
          end else if (deb_cnt != DEB_MAX) begin
            deb_n = deb_cnt + 1'b1;
          end
        end else begin
          deb_n = '0;
        end
      end
      default: begin
        state_n = SCAN;
      end
    endcase
  end

  assign col_o           = ~(4'b0001 << col);
  assign key_if.num      = num_r;
  assign key_if.load_num = (state == EMIT);
  assign key_if.key_held = (state == EMIT) || (state == HOLD);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder with a behavioural 4x4 keypad
// and a queue of expected key codes consumed as strobes appear.
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] pressed;

  int         checks;
  int         errors;
  int         strobe_cnt;
  logic       prev_load;
  logic [3:0] exp_q[$];

  keypad_scan_encoder_if kif ();

  keypad_scan_encoder #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .row_i  (row_i),
    .col_o  (col_o),
    .key_if (kif)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic press_key(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    pressed[r*4+c] = 1'b0;
  endtask

  // Advance n cycles, sampling on the falling edge and scoring every strobe.
  task automatic tick(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (kif.load_num === 1'b1) begin
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_strobe: got num=%h, expected no strobe", kif.num);
        end else begin
          e = exp_q.pop_front();
          if (kif.num !== e) begin
            errors++;
            $display("[TB] FAIL strobe_num: got %h expected %h", kif.num, e);
          end
        end
        checks++;
        if (prev_load === 1'b1) begin
          errors++;
          $display("[TB] FAIL double_strobe: load_num high two cycles, expected single pulse");
        end
        checks++;
        if (kif.key_held !== 1'b1) begin
          errors++;
          $display("[TB] FAIL held_at_strobe: got key_held=%b expected 1", kif.key_held);
        end
      end
      prev_load = kif.load_num;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    tick(5);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (col_o !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col_o: got %b expected 1110", col_o); end
    checks++;
    if (kif.num !== 4'h0) begin errors++; $display("[TB] FAIL reset_num: got %h expected 0", kif.num); end
    checks++;
    if (kif.load_num !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_num: got %b expected 0", kif.load_num); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_held: got %b expected 0", kif.key_held); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col_o !== exp_col) begin
        errors++;
        $display("[TB] FAIL scan_rotation cycle %0d: got %b expected %b", k, col_o, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    int s0;
    s0 = strobe_cnt;
    exp_q.push_back(4'hB);
    press_key(3, 2);
    tick(40);
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL clean_press_count: got %0d strobes expected 1", strobe_cnt - s0); end
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("[TB] FAIL clean_press_held: got %b expected 1", kif.key_held); end
    checks++;
    if (col_o !== 4'b1011) begin errors++; $display("[TB] FAIL clean_press_col: got %b expected 1011", col_o); end
    release_key(3, 2);
    tick(9);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("[TB] FAIL release_held_early: got %b expected 1", kif.key_held); end
    tick(1);
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("[TB] FAIL release_held_late: got %b expected 0", kif.key_held); end
    checks++;
    if (col_o !== 4'b1110) begin errors++; $display("[TB] FAIL release_scan_restart: got %b expected 1110", col_o); end
    tick(10);
  endtask

  task automatic test_bounce();
    int s0;
    s0 = strobe_cnt;
    for (int g = 0; g < 3; g++) begin
      press_key(1, 1);
      tick(3);
      release_key(1, 1);
      tick(2);
    end
    tick(4);
    checks++;
    if (strobe_cnt != s0) begin errors++; $display("[TB] FAIL bounce_glitch: got %0d strobes expected 0", strobe_cnt - s0); end
    exp_q.push_back(4'h5);
    press_key(1, 1);
    tick(40);
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL bounce_count: got %0d strobes expected 1", strobe_cnt - s0); end
    release_key(1, 1);
    tick(20);
    checks++;
    if (kif.num !== 4'h5) begin errors++; $display("[TB] FAIL bounce_num_hold: got %h expected 5", kif.num); end
  endtask

  task automatic test_short_tap();
    int   s0;
    logic found;
    logic [3:0] prev;
    s0    = strobe_cnt;
    found = 1'b0;
    prev  = col_o;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (prev == 4'b0111 && col_o == 4'b1110) found = 1'b1;
      prev = col_o;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL short_tap_align: got no 0111->1110 column wrap within 40 cycles, expected one");
    end
    press_key(2, 0);
    tick(6);
    release_key(2, 0);
    tick(2);
    checks++;
    if (col_o !== 4'b1110) begin errors++; $display("[TB] FAIL short_tap_col_hold: got %b expected 1110", col_o); end
    tick(1);
    checks++;
    if (col_o !== 4'b1101) begin errors++; $display("[TB] FAIL short_tap_next_col: got %b expected 1101", col_o); end
    tick(10);
    checks++;
    if (strobe_cnt != s0) begin errors++; $display("[TB] FAIL short_tap_count: got %0d strobes expected 0", strobe_cnt - s0); end
  endtask

  task automatic test_two_keys();
    int s0;
    s0 = strobe_cnt;
    exp_q.push_back(4'h1);
    press_key(0, 0);
    press_key(1, 0);
    tick(40);
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL two_keys_first: got %0d strobes expected 1", strobe_cnt - s0); end
    exp_q.push_back(4'h4);
    release_key(0, 0);
    tick(40);
    checks++;
    if (strobe_cnt - s0 != 2) begin errors++; $display("[TB] FAIL two_keys_second: got %0d strobes expected 2", strobe_cnt - s0); end
    release_key(1, 0);
    tick(20);
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("[TB] FAIL two_keys_release: got key_held=%b expected 0", kif.key_held); end
  endtask

  task automatic test_back_to_back();
    int         s0;
    int         rs[4];
    int         cs[4];
    logic [3:0] codes[4];
    rs = '{0, 0, 0, 3};
    cs = '{0, 1, 2, 2};
    codes = '{4'h1, 4'h2, 4'h3, 4'hB};
    s0 = strobe_cnt;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(codes[k]);
      press_key(rs[k], cs[k]);
      tick(40);
      release_key(rs[k], cs[k]);
      tick(20);
      checks++;
      if (kif.num !== codes[k]) begin
        errors++;
        $display("[TB] FAIL sequence_num_hold %0d: got %h expected %h", k, kif.num, codes[k]);
      end
    end
    checks++;
    if (strobe_cnt - s0 != 4) begin errors++; $display("[TB] FAIL sequence_count: got %0d strobes expected 4", strobe_cnt - s0); end
  endtask

  task automatic test_reset_midop();
    int s0;
    s0 = strobe_cnt;
    exp_q.push_back(4'h2);
    press_key(0, 1);
    tick(40);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("[TB] FAIL midop_held: got %b expected 1", kif.key_held); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (kif.num !== 4'h0) begin errors++; $display("[TB] FAIL midop_reset_num: got %h expected 0", kif.num); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("[TB] FAIL midop_reset_held: got %b expected 0", kif.key_held); end
    checks++;
    if (col_o !== 4'b1110) begin errors++; $display("[TB] FAIL midop_reset_col: got %b expected 1110", col_o); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'h2);
    tick(40);
    checks++;
    if (strobe_cnt - s0 != 2) begin errors++; $display("[TB] FAIL midop_repress: got %0d strobes expected 2", strobe_cnt - s0); end
    release_key(0, 1);
    tick(20);
  endtask

  // Single sequential driver: reset, then each scenario in turn.
  initial begin
    checks     = 0;
    errors     = 0;
    strobe_cnt = 0;
    prev_load  = 1'b0;
    pressed    = '0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] starting keypad_scan_encoder bench");
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_tap();
    test_two_keys();
    test_back_to_back();
    test_reset_midop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending codes expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
